pair_mismatch_monitor: RTL and testbench

PAIR_MISMATCH_MONITOR -- requirements
Module: pair_mismatch_monitor

---
 rtl/pair_mismatch_monitor.sv | 96 +++++++++
 tb/tb_pair_mismatch_monitor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pair_mismatch_monitor.sv
// Compares the two outputs of a redundant circuit pair and declares a sticky fault after THRESH consecutive mismatches.
// Latency: every output reflects a valid sample one cycle later. There is no backpressure: a sample is taken whenever en_i is high.
// Soft clear (clr_i) and reset (rst_i) both return the block to IDLE with all counters zeroed.
module pair_mismatch_monitor #(
    parameter int CNT_W  = 16,
    parameter int THRESH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic             o1_i,
    input  logic             o2_i,
    output logic             mism_o,
    output logic             fault_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] mism_cnt_o,
    output logic [CNT_W-1:0] run_o,
    output logic [CNT_W-1:0] smp_cnt_o,
    output logic [CNT_W-1:0] first_idx_o,
    output logic             first_vld_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        SUSPECT = 2'b10,
        FAULT   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

    state_t           state_q;
    state_t           state_d;
    logic             smp_vld;
    logic             mism;
    logic [CNT_W-1:0] run_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Reset priority over clear and enable is resolved in the registers below.
    assign smp_vld = en_i & ~clr_i;
    assign mism    = o1_i ^ o2_i;
    assign run_d   = mism ? sat_inc(run_o) : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (smp_vld && (state_q != FAULT)) begin
            if (!mism) begin
                state_d = MONITOR;
            end else if (run_d >= THRESH_C) begin
                state_d = FAULT;
            end else begin
                state_d = SUSPECT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            mism_o      <= 1'b0;
            mism_cnt_o  <= '0;
            run_o       <= '0;
            smp_cnt_o   <= '0;
            first_idx_o <= '0;
            first_vld_o <= 1'b0;
        end else if (en_i) begin
            mism_o    <= mism;
            smp_cnt_o <= sat_inc(smp_cnt_o);
            run_o     <= run_d;
            if (mism) begin
                mism_cnt_o <= sat_inc(mism_cnt_o);
                // Capture the sample index of the first mismatch only once.
                if (!first_vld_o) begin
                    first_idx_o <= smp_cnt_o;
                    first_vld_o <= 1'b1;
                end
            end
        end
    end

    assign state_o = state_q;
    assign fault_o = (state_q == FAULT);

endmodule

// File: tb/tb_pair_mismatch_monitor.sv
// Bench for pair_mismatch_monitor: directed scenarios plus random traffic on two instances (THRESH=3 and THRESH=1).
module tb_pair_mismatch_monitor;

    localparam int W    = 4;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic o1  = 1'b0;
    logic o2  = 1'b0;

    logic         mism_w  [2];
    logic         fault_w [2];
    logic [1:0]   state_w [2];
    logic [W-1:0] mcnt_w  [2];
    logic [W-1:0] run_w   [2];
    logic [W-1:0] smp_w   [2];
    logic [W-1:0] fidx_w  [2];
    logic         fvld_w  [2];

    int total = 0;
    int bad   = 0;

    // Reference model: counts, run length and flags for each instance.
    int thr    [2] = '{3, 1};
    int m_smp  [2];
    int m_mc   [2];
    int m_run  [2];
    int m_fi   [2];
    bit m_fv   [2];
    bit m_flt  [2];
    bit m_last [2];
    bit m_seen [2];

    always #5 clk = ~clk;

    pair_mismatch_monitor #(.CNT_W(W), .THRESH(3)) dut0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .o1_i(o1), .o2_i(o2),
        .mism_o(mism_w[0]), .fault_o(fault_w[0]), .state_o(state_w[0]),
        .mism_cnt_o(mcnt_w[0]), .run_o(run_w[0]), .smp_cnt_o(smp_w[0]),
        .first_idx_o(fidx_w[0]), .first_vld_o(fvld_w[0])
    );

    pair_mismatch_monitor #(.CNT_W(W), .THRESH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_i(clr), .o1_i(o1), .o2_i(o2),
        .mism_o(mism_w[1]), .fault_o(fault_w[1]), .state_o(state_w[1]),
        .mism_cnt_o(mcnt_w[1]), .run_o(run_w[1]), .smp_cnt_o(smp_w[1]),
        .first_idx_o(fidx_w[1]), .first_vld_o(fvld_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_state(input int k);
        if (m_flt[k]) return 3;
        if (!m_seen[k]) return 0;
        return m_last[k] ? 2 : 1;
    endfunction

    task automatic model(input bit r, input bit c, input bit e, input bit a, input bit b);
        for (int k = 0; k < 2; k++) begin
            if (r || c) begin
                m_smp[k] = 0; m_mc[k] = 0; m_run[k] = 0; m_fi[k] = 0;
                m_fv[k] = 0; m_flt[k] = 0; m_last[k] = 0; m_seen[k] = 0;
            end else if (e) begin
                if (a != b) begin
                    if (!m_fv[k]) begin
                        m_fi[k] = m_smp[k];
                        m_fv[k] = 1;
                    end
                    m_mc[k]  = (m_mc[k] < MAXC) ? m_mc[k] + 1 : MAXC;
                    m_run[k] = (m_run[k] < MAXC) ? m_run[k] + 1 : MAXC;
                    if (m_run[k] >= thr[k]) m_flt[k] = 1;
                end else begin
                    m_run[k] = 0;
                end
                m_smp[k]  = (m_smp[k] < MAXC) ? m_smp[k] + 1 : MAXC;
                m_last[k] = (a != b);
                m_seen[k] = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d_state", k), 32'(state_w[k]), exp_state(k));
            chk($sformatf("d%0d_fault", k), 32'(fault_w[k]), 32'(m_flt[k]));
            chk($sformatf("d%0d_mism", k),  32'(mism_w[k]),  32'(m_last[k]));
            chk($sformatf("d%0d_smp", k),   32'(smp_w[k]),   m_smp[k]);
            chk($sformatf("d%0d_mcnt", k),  32'(mcnt_w[k]),  m_mc[k]);
            chk($sformatf("d%0d_run", k),   32'(run_w[k]),   m_run[k]);
            chk($sformatf("d%0d_fvld", k),  32'(fvld_w[k]),  32'(m_fv[k]));
            chk($sformatf("d%0d_fidx", k),  32'(fidx_w[k]),  m_fi[k]);
        end
    endtask

    // One clock: drive on the falling edge, update the model at the rising edge, sample 1ns later.
    task automatic step(input bit r, input bit c, input bit e, input bit a, input bit b);
        @(negedge clk);
        rst = r; clr = c; en = e; o1 = a; o2 = b;
        @(posedge clk);
        model(r, c, e, a, b);
        #1;
        check_all();
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("rst_state", 32'(state_w[0]), 0);
        chk("rst_smp", 32'(smp_w[0]), 0);

        // Matching stream of 5 samples
        for (int i = 0; i < 5; i++) step(0, 0, 1, i[0], i[0]);
        chk("match5_state", 32'(state_w[0]), 1);
        chk("match5_smp", 32'(smp_w[0]), 5);

        // M,X,X,M
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 1);
        chk("mxx_state", 32'(state_w[0]), 2);
        chk("mxx_run", 32'(run_w[0]), 2);
        step(0, 0, 1, 0, 0);
        chk("mxxm_state", 32'(state_w[0]), 1);
        chk("mxxm_fidx", 32'(fidx_w[0]), 1);
        chk("mxxm_mcnt", 32'(mcnt_w[0]), 2);

        // Three X then M: fault, sticky
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0);
        chk("xxx_fault", 32'(fault_w[0]), 1);
        step(0, 0, 1, 1, 1);
        chk("fault_sticky", 32'(state_w[0]), 3);

        // X with enable gaps
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 1);
            step(0, 0, 0, 1, 1);
            step(0, 0, 0, 0, 1);
        end
        chk("gap_fault", 32'(fault_w[0]), 1);

        // 20 X: saturation
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 0);
        chk("sat_smp", 32'(smp_w[0]), 15);
        chk("sat_mcnt", 32'(mcnt_w[0]), 15);
        chk("sat_run", 32'(run_w[0]), 15);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

        // Clear with a mismatching enabled sample while in FAULT
        step(0, 1, 1, 1, 0);
        chk("clr_state", 32'(state_w[0]), 0);
        chk("clr_smp", 32'(smp_w[0]), 0);

        // Reset in FAULT, with enable high
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
        step(1, 0, 1, 0, 1);
        chk("rst_fault", 32'(fault_w[0]), 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
